fir_run_scheduler: RTL and testbench

- Sequences the two FIR engines (non-pipelined and pipelined) that share the 1024x8 dual-port sample memory.
- Arbitrates memory ownership between the host loader and the engines.
- Issues start pulses and waits for done, with a timeout.
- Captures per-engine cycle counts and reports a comparison result.
- Sits inside fir_top between the host/test interface and the engine/memory muxes.

---
 rtl/fir_run_scheduler_if.sv | 37 +++
 rtl/fir_run_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_fir_run_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_run_scheduler_if.sv
// Handshake bundle between the FIR run scheduler and its surroundings:
// host loader arbitration, run requests, engine start/done and the result report.
interface fir_run_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             host_req;
    logic             host_gnt;
    logic             req_valid;
    logic [1:0]       req_mode;
    logic             req_ready;
    logic             busy;
    logic             eng_start_np;
    logic             eng_start_p;
    logic             eng_done_np;
    logic             eng_done_p;
    logic [1:0]       mem_owner;
    logic             rpt_valid;
    logic [CNT_W-1:0] cyc_np;
    logic [CNT_W-1:0] cyc_p;
    logic             timeout_np;
    logic             timeout_p;
    logic             p_faster;

    // Scheduler side.
    modport master (
        input  host_req, req_valid, req_mode, eng_done_np, eng_done_p,
        output host_gnt, req_ready, busy, eng_start_np, eng_start_p, mem_owner,
               rpt_valid, cyc_np, cyc_p, timeout_np, timeout_p, p_faster
    );

    // Host / engine side.
    modport slave (
        output host_req, req_valid, req_mode, eng_done_np, eng_done_p,
        input  host_gnt, req_ready, busy, eng_start_np, eng_start_p, mem_owner,
               rpt_valid, cyc_np, cyc_p, timeout_np, timeout_p, p_faster
    );
endinterface

// File: rtl/fir_run_scheduler.sv
// Sequences the non-pipelined and pipelined FIR engines over the shared sample
// memory: arbitrates host vs engine ownership, pulses engine starts, waits for
// done with a timeout, captures cycle counts and reports which engine was faster.
module fir_run_scheduler #(
    parameter int CNT_W     = 16,
    parameter int START_LEN = 1,
    parameter int TIMEOUT   = 8192,
    parameter int GAP       = 4
) (
    input  logic                clk,
    input  logic                rst,
    fir_run_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOST,
        S_START,
        S_WAIT,
        S_GAP,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);
    // GAP = 0 still spends one cycle in the GAP state with the memory released.
    localparam logic [3:0]       GAP_LAST   = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_P    = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_NP   = 2'd1;
    localparam logic [1:0] OWN_P    = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             sel_p_q, sel_p_d;       // 0: non-pipelined engine, 1: pipelined
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             host_gnt_q, host_gnt_d;
    logic             busy_q, busy_d;
    logic             start_np_q, start_np_d;
    logic             start_p_q, start_p_d;
    logic [1:0]       owner_q, owner_d;
    logic             rpt_q, rpt_d;
    logic [CNT_W-1:0] cyc_np_q, cyc_np_d;
    logic [CNT_W-1:0] cyc_p_q, cyc_p_d;
    logic             to_np_q, to_np_d;
    logic             to_p_q, to_p_d;
    logic             faster_q, faster_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             done_sel;

    // Saturating run counter increment and done of the currently selected engine.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign done_sel = sel_p_q ? bus.eng_done_p : bus.eng_done_np;

    // Next-state and registered-output logic for the run sequencer.
    always_comb begin
        // NOTE: every _d defaults to its _q so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        sel_p_d    = sel_p_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        host_gnt_d = host_gnt_q;
        busy_d     = busy_q;
        start_np_d = start_np_q;
        start_p_d  = start_p_q;
        owner_d    = owner_q;
        rpt_d      = 1'b0;
        cyc_np_d   = cyc_np_q;
        cyc_p_d    = cyc_p_q;
        to_np_d    = to_np_q;
        to_p_d     = to_p_q;
        faster_d   = faster_q;

        case (state_q)
            S_IDLE: begin
                if (bus.host_req) begin
                    state_d    = S_HOST;
                    host_gnt_d = 1'b1;
                end else if (bus.req_valid) begin
                    mode_d   = bus.req_mode;
                    cyc_np_d = '0;
                    cyc_p_d  = '0;
                    to_np_d  = 1'b0;
                    to_p_d   = 1'b0;
                    faster_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    if (bus.req_mode == MODE_NONE) begin
                        state_d = S_REPORT;
                        rpt_d   = 1'b1;
                    end else if (bus.req_mode == MODE_P) begin
                        state_d   = S_START;
                        sel_p_d   = 1'b1;
                        owner_d   = OWN_P;
                        start_p_d = 1'b1;
                    end else begin
                        state_d    = S_START;
                        sel_p_d    = 1'b0;
                        owner_d    = OWN_NP;
                        start_np_d = 1'b1;
                    end
                end
            end

            S_HOST: begin
                if (!bus.host_req) begin
                    state_d    = S_IDLE;
                    host_gnt_d = 1'b0;
                end
            end

            S_START: begin
                // Done is deliberately ignored here so a level left over from
                // the previous run cannot end this one.
                cnt_d = cnt_inc;
                if (cnt_q >= START_LAST) begin
                    state_d    = S_WAIT;
                    start_np_d = 1'b0;
                    start_p_d  = 1'b0;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_inc;
                // cnt_q equals the index of the current cycle (first start
                // cycle = 0), so it is the done index as captured.
                if (done_sel) begin
                    if (sel_p_q) cyc_p_d  = cnt_q;
                    else         cyc_np_d = cnt_q;
                    state_d = S_GAP;
                    owner_d = OWN_NONE;
                    gap_d   = '0;
                end else if (cnt_q >= TO_LAST) begin
                    if (sel_p_q) begin
                        cyc_p_d = TO_VAL;
                        to_p_d  = 1'b1;
                    end else begin
                        cyc_np_d = TO_VAL;
                        to_np_d  = 1'b1;
                    end
                    state_d = S_GAP;
                    owner_d = OWN_NONE;
                    gap_d   = '0;
                end
            end

            S_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    if (mode_q == MODE_BOTH && !sel_p_q) begin
                        state_d   = S_START;
                        sel_p_d   = 1'b1;
                        owner_d   = OWN_P;
                        start_p_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d  = S_REPORT;
                        rpt_d    = 1'b1;
                        faster_d = (mode_q == MODE_BOTH) && !to_np_q && !to_p_q &&
                                   (cyc_p_q < cyc_np_q);
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end

            S_REPORT: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the memory and drops starts at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            sel_p_q    <= 1'b0;
            cnt_q      <= '0;
            gap_q      <= '0;
            host_gnt_q <= 1'b0;
            busy_q     <= 1'b0;
            start_np_q <= 1'b0;
            start_p_q  <= 1'b0;
            owner_q    <= OWN_NONE;
            rpt_q      <= 1'b0;
            cyc_np_q   <= '0;
            cyc_p_q    <= '0;
            to_np_q    <= 1'b0;
            to_p_q     <= 1'b0;
            faster_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            sel_p_q    <= sel_p_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            host_gnt_q <= host_gnt_d;
            busy_q     <= busy_d;
            start_np_q <= start_np_d;
            start_p_q  <= start_p_d;
            owner_q    <= owner_d;
            rpt_q      <= rpt_d;
            cyc_np_q   <= cyc_np_d;
            cyc_p_q    <= cyc_p_d;
            to_np_q    <= to_np_d;
            to_p_q     <= to_p_d;
            faster_q   <= faster_d;
        end
    end

    // A host request blocks acceptance in the very cycle it appears.
    assign bus.req_ready    = (state_q == S_IDLE) && !bus.host_req;
    assign bus.host_gnt     = host_gnt_q;
    assign bus.busy         = busy_q;
    assign bus.eng_start_np = start_np_q;
    assign bus.eng_start_p  = start_p_q;
    assign bus.mem_owner    = owner_q;
    assign bus.rpt_valid    = rpt_q;
    assign bus.cyc_np       = cyc_np_q;
    assign bus.cyc_p        = cyc_p_q;
    assign bus.timeout_np   = to_np_q;
    assign bus.timeout_p    = to_p_q;
    assign bus.p_faster     = faster_q;

endmodule

// File: tb/tb_fir_run_scheduler.sv
// Self-checking bench for fir_run_scheduler. Instance A uses the default
// parameters; instance B uses START_LEN = 3 and TIMEOUT = 64. A small engine
// model per instance raises done a programmed number of cycles after its start.
module tb_fir_run_scheduler;

    localparam int CNT_W = 16;
    localparam int GAP   = 4;
    localparam int SL_A  = 1;
    localparam int TO_A  = 8192;
    localparam int SL_B  = 3;
    localparam int TO_B  = 64;

    typedef struct packed {
        logic             host_gnt;
        logic             req_ready;
        logic             busy;
        logic             eng_start_np;
        logic             eng_start_p;
        logic [1:0]       mem_owner;
        logic             rpt_valid;
        logic [CNT_W-1:0] cyc_np;
        logic [CNT_W-1:0] cyc_p;
        logic             timeout_np;
        logic             timeout_p;
        logic             p_faster;
    } dut_out_t;

    typedef struct {
        int         inst;
        logic [1:0] mode;
        int         dnp;     // done index of the np engine, -1 = never
        int         dp;      // done index of the p engine, -1 = never
        int         hold;    // np done kept high for this many cycles after start
        int         cyc_np;
        int         cyc_p;
        bit         to_np;
        bit         to_p;
        bit         pf;
    } vec_t;

    logic clk;
    logic rst;

    logic       tb_host_req  [2];
    logic       tb_req_valid [2];
    logic [1:0] tb_req_mode  [2];
    logic       tb_done_np   [2];
    logic       tb_done_p    [2];

    int errors;
    int checks;
    int tcyc;

    int       idx_np [2];
    int       idx_p  [2];
    int       done_at_np [2];
    int       done_at_p  [2];
    int       hold_np [2];
    logic     prev_snp [2];
    logic     prev_sp  [2];
    int       rpt_cnt [2];
    int       snp_cnt [2];
    int       sp_cnt  [2];
    int       np_start [2];
    int       p_start  [2];
    logic [2:0] own_mask [2];

    dut_out_t out_a;
    dut_out_t out_b;

    fir_run_scheduler_if #(.CNT_W(CNT_W)) if_a ();
    fir_run_scheduler_if #(.CNT_W(CNT_W)) if_b ();

    fir_run_scheduler #(.CNT_W(CNT_W), .START_LEN(SL_A), .TIMEOUT(TO_A), .GAP(GAP)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.master)
    );

    fir_run_scheduler #(.CNT_W(CNT_W), .START_LEN(SL_B), .TIMEOUT(TO_B), .GAP(GAP)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.master)
    );

    assign if_a.host_req    = tb_host_req[0];
    assign if_a.req_valid   = tb_req_valid[0];
    assign if_a.req_mode    = tb_req_mode[0];
    assign if_a.eng_done_np = tb_done_np[0];
    assign if_a.eng_done_p  = tb_done_p[0];
    assign if_b.host_req    = tb_host_req[1];
    assign if_b.req_valid   = tb_req_valid[1];
    assign if_b.req_mode    = tb_req_mode[1];
    assign if_b.eng_done_np = tb_done_np[1];
    assign if_b.eng_done_p  = tb_done_p[1];

    assign out_a = {if_a.host_gnt, if_a.req_ready, if_a.busy, if_a.eng_start_np,
                    if_a.eng_start_p, if_a.mem_owner, if_a.rpt_valid, if_a.cyc_np,
                    if_a.cyc_p, if_a.timeout_np, if_a.timeout_p, if_a.p_faster};
    assign out_b = {if_b.host_gnt, if_b.req_ready, if_b.busy, if_b.eng_start_np,
                    if_b.eng_start_p, if_b.mem_owner, if_b.rpt_valid, if_b.cyc_np,
                    if_b.cyc_p, if_b.timeout_np, if_b.timeout_p, if_b.p_faster};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic dut_out_t get_out(input int k);
        if (k == 0) return out_a;
        return out_b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: advance to just after the edge, then run the engine models and monitors.
    task automatic tick();
        dut_out_t o;
        @(posedge clk);
        #1;
        tcyc++;
        for (int k = 0; k < 2; k++) begin
            o = get_out(k);
            if (o.eng_start_np && !prev_snp[k]) begin
                idx_np[k]   = 0;
                np_start[k] = tcyc;
            end else begin
                idx_np[k]++;
            end
            if (o.eng_start_p && !prev_sp[k]) begin
                idx_p[k]   = 0;
                p_start[k] = tcyc;
            end else begin
                idx_p[k]++;
            end
            tb_done_np[k] = (idx_np[k] < hold_np[k]) ||
                            (done_at_np[k] >= 0 && idx_np[k] >= done_at_np[k]);
            tb_done_p[k]  = (done_at_p[k] >= 0 && idx_p[k] >= done_at_p[k]);
            if (o.eng_start_np) snp_cnt[k]++;
            if (o.eng_start_p)  sp_cnt[k]++;
            if (o.rpt_valid)    rpt_cnt[k]++;
            if (o.mem_owner == 2'd1) own_mask[k][0] = 1'b1;
            if (o.mem_owner == 2'd2) own_mask[k][1] = 1'b1;
            if (o.mem_owner == 2'd3) own_mask[k][2] = 1'b1;
            prev_snp[k] = o.eng_start_np;
            prev_sp[k]  = o.eng_start_p;
        end
    endtask

    task automatic clear_mon(input int k);
        rpt_cnt[k]  = 0;
        snp_cnt[k]  = 0;
        sp_cnt[k]   = 0;
        np_start[k] = -1;
        p_start[k]  = -1;
        own_mask[k] = '0;
    endtask

    task automatic wait_rpt(input int k, input int budget);
        int n;
        n = 0;
        while (rpt_cnt[k] == 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    vec_t     vecs [11];
    dut_out_t o;
    dut_out_t exp_rst;
    int       sl;
    int       to;
    int       bad;

    initial begin
        errors = 0;
        checks = 0;
        tcyc   = 0;
        for (int k = 0; k < 2; k++) begin
            tb_host_req[k]  = 1'b0;
            tb_req_valid[k] = 1'b0;
            tb_req_mode[k]  = 2'b00;
            tb_done_np[k]   = 1'b0;
            tb_done_p[k]    = 1'b0;
            idx_np[k]       = 0;
            idx_p[k]        = 0;
            done_at_np[k]   = -1;
            done_at_p[k]    = -1;
            hold_np[k]      = 0;
            prev_snp[k]     = 1'b0;
            prev_sp[k]      = 1'b0;
            clear_mon(k);
        end

        //            inst mode   dnp   dp   hold cyc_np cyc_p to_np to_p pf
        vecs[0]  = '{0, 2'b01,   37,  -1,  0,   37,     0,   0,    0,   0};
        vecs[1]  = '{0, 2'b11, 1050, 215,  0, 1050,   215,   0,    0,   1};
        vecs[2]  = '{0, 2'b10,   -1,  20,  0,    0,    20,   0,    0,   0};
        vecs[3]  = '{0, 2'b11,   30,  30,  0,   30,    30,   0,    0,   0};
        vecs[4]  = '{0, 2'b11,   12,  40,  0,   12,    40,   0,    0,   0};
        vecs[5]  = '{0, 2'b00,   -1,  -1,  0,    0,     0,   0,    0,   0};
        vecs[6]  = '{1, 2'b10,   -1,  -1,  0,    0,    64,   0,    1,   0};
        vecs[7]  = '{1, 2'b11,   -1,  10,  0,   64,    10,   1,    0,   0};
        vecs[8]  = '{1, 2'b01,   63,  -1,  0,   63,     0,   0,    0,   0};
        vecs[9]  = '{1, 2'b01,    2,  -1,  0,    3,     0,   0,    0,   0};
        vecs[10] = '{1, 2'b01,   10,  -1,  3,   10,     0,   0,    0,   0};

        // Reset state of both instances.
        rst = 1'b1;
        #12;
        exp_rst           = '0;
        exp_rst.req_ready = 1'b1;
        check("reset_state_a", 64'(out_a), 64'(exp_rst));
        check("reset_state_b", 64'(out_b), 64'(exp_rst));
        tick();
        rst = 1'b0;
        tick();

        // Table-driven runs.
        for (int i = 0; i < 11; i++) begin
            int k;
            k  = vecs[i].inst;
            sl = (k == 0) ? SL_A : SL_B;
            to = (k == 0) ? TO_A : TO_B;
            done_at_np[k] = vecs[i].dnp;
            done_at_p[k]  = vecs[i].dp;
            hold_np[k]    = vecs[i].hold;
            clear_mon(k);
            tb_req_valid[k] = 1'b1;
            tb_req_mode[k]  = vecs[i].mode;
            #1;
            o = get_out(k);
            check($sformatf("row%0d_req_ready", i), 64'(o.req_ready), 64'd1);
            tick();
            tb_req_valid[k] = 1'b0;
            wait_rpt(k, 3000);
            o = get_out(k);
            check($sformatf("row%0d_rpt_seen", i), 64'(rpt_cnt[k]), 64'd1);
            check($sformatf("row%0d_cyc_np", i), 64'(o.cyc_np), 64'(vecs[i].cyc_np));
            check($sformatf("row%0d_cyc_p", i), 64'(o.cyc_p), 64'(vecs[i].cyc_p));
            check($sformatf("row%0d_timeout_np", i), 64'(o.timeout_np), 64'(vecs[i].to_np));
            check($sformatf("row%0d_timeout_p", i), 64'(o.timeout_p), 64'(vecs[i].to_p));
            check($sformatf("row%0d_p_faster", i), 64'(o.p_faster), 64'(vecs[i].pf));
            check($sformatf("row%0d_rpt_owner", i), 64'(o.mem_owner), 64'd0);
            check($sformatf("row%0d_rpt_busy", i), 64'(o.busy), 64'd1);
            check($sformatf("row%0d_start_np_len", i), 64'(snp_cnt[k]),
                  64'(vecs[i].mode[0] ? sl : 0));
            check($sformatf("row%0d_start_p_len", i), 64'(sp_cnt[k]),
                  64'(vecs[i].mode[1] ? sl : 0));
            check($sformatf("row%0d_owner_mask", i), 64'(own_mask[k]), 64'({1'b0, vecs[i].mode}));
            if (vecs[i].mode == 2'b11) begin
                // p start follows the np done sample (or the timeout cycle) by GAP+1.
                check($sformatf("row%0d_p_start_gap", i), 64'(p_start[k] - np_start[k]),
                      64'((vecs[i].to_np ? to - 1 : vecs[i].cyc_np) + GAP + 1));
            end
            tick();
            tick();
            tick();
            o = get_out(k);
            check($sformatf("row%0d_rpt_once", i), 64'(rpt_cnt[k]), 64'd1);
            check($sformatf("row%0d_idle_busy", i), 64'(o.busy), 64'd0);
            check($sformatf("row%0d_idle_ready", i), 64'(o.req_ready), 64'd1);
            check($sformatf("row%0d_hold_cyc_np", i), 64'(o.cyc_np), 64'(vecs[i].cyc_np));
        end

        // host_req and req_valid together: host wins, request waits for release.
        done_at_np[0] = 5;
        done_at_p[0]  = -1;
        hold_np[0]    = 0;
        clear_mon(0);
        tb_host_req[0]  = 1'b1;
        tb_req_valid[0] = 1'b1;
        tb_req_mode[0]  = 2'b01;
        #1;
        check("host_same_cycle_ready", 64'(out_a.req_ready), 64'd0);
        tick();
        check("host_gnt_set", 64'(out_a.host_gnt), 64'd1);
        check("host_busy", 64'(out_a.busy), 64'd0);
        check("host_owner", 64'(out_a.mem_owner), 64'd0);
        bad = 0;
        for (int c = 0; c < 1023; c++) begin
            tick();
            if (out_a.host_gnt !== 1'b1 || out_a.req_ready !== 1'b0 || out_a.busy !== 1'b0)
                bad++;
        end
        check("host_held_1024", 64'(bad), 64'd0);
        tb_host_req[0] = 1'b0;
        #1;
        check("host_release_ready", 64'(out_a.req_ready), 64'd0);
        tick();
        check("host_gnt_drop", 64'(out_a.host_gnt), 64'd0);
        check("host_after_ready", 64'(out_a.req_ready), 64'd1);
        tick();
        tb_req_valid[0] = 1'b0;
        check("host_accept_busy", 64'(out_a.busy), 64'd1);
        check("host_accept_start", 64'(out_a.eng_start_np), 64'd1);
        wait_rpt(0, 200);
        check("host_run_rpt", 64'(rpt_cnt[0]), 64'd1);
        check("host_run_cyc_np", 64'(out_a.cyc_np), 64'd5);
        tick();
        tick();

        // Reset mid-run: A in WAIT, B in START.
        done_at_np[0] = -1;
        done_at_np[1] = -1;
        done_at_p[1]  = -1;
        hold_np[1]    = 0;
        clear_mon(0);
        clear_mon(1);
        tb_req_valid[0] = 1'b1;
        tb_req_mode[0]  = 2'b01;
        tick();
        tb_req_valid[0] = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        tb_req_valid[1] = 1'b1;
        tb_req_mode[1]  = 2'b01;
        tick();
        tb_req_valid[1] = 1'b0;
        check("pre_rst_a_owner", 64'(out_a.mem_owner), 64'd1);
        check("pre_rst_a_busy", 64'(out_a.busy), 64'd1);
        check("pre_rst_b_start", 64'(out_b.eng_start_np), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_a_owner", 64'(out_a.mem_owner), 64'd0);
        check("rst_a_busy", 64'(out_a.busy), 64'd0);
        check("rst_a_ready", 64'(out_a.req_ready), 64'd1);
        check("rst_a_start", 64'({out_a.eng_start_np, out_a.eng_start_p}), 64'd0);
        check("rst_b_start", 64'({out_b.eng_start_np, out_b.eng_start_p}), 64'd0);
        check("rst_b_owner", 64'(out_b.mem_owner), 64'd0);
        check("rst_b_busy", 64'(out_b.busy), 64'd0);
        check("rst_b_ready", 64'(out_b.req_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("rst_no_rpt_a", 64'(rpt_cnt[0]), 64'd0);
        check("rst_no_rpt_b", 64'(rpt_cnt[1]), 64'd0);
        check("rst_idle_a", 64'(out_a.busy), 64'd0);
        check("rst_idle_b", 64'(out_b.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
